// File: rtl/serial_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : serial_pkg
//  Description : Shared FSM state encoding and default sync-frame constants
//                used by serial_frame_arb and the serial_detect benches.
//  Revision    : 1.0 - initial release
// ============================================================================
package serial_pkg;

    // Default frame geometry, shared with the downstream serial_detect.
    localparam int         c_len_def = 5;
    localparam logic [4:0] c_std_def = 5'b01110;
    localparam int         c_dw_def  = 8;
    localparam int         c_gap_def = 2;

    // Frame FSM encoding; ST_PAR is only reachable in parity builds.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SYNC    = 3'd1,
        ST_ID      = 3'd2,
        ST_PAYLOAD = 3'd3,
        ST_PAR     = 3'd4,
        ST_GAP     = 3'd5
    } state_t;

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/serial_frame_arb_if.sv
`default_nettype none
// ============================================================================
//  Module      : serial_frame_arb_if
//  Description : Requester-side bus of serial_frame_arb: level requests,
//                packed payloads, grant pulses and the serial frame line.
//  Revision    : 1.0 - initial release
// ============================================================================
interface serial_frame_arb_if #(
    parameter int NREQ = 4,
    parameter int DW   = 8
);
    logic [NREQ-1:0]    req;
    logic [NREQ*DW-1:0] dat;
    logic [NREQ-1:0]    gnt;
    logic               dat_out;
    logic               busy;
    logic               frame_done;

    // Requester side drives requests/payloads.
    modport master (output req, dat, input gnt, dat_out, busy, frame_done);
    // Arbiter side consumes requests and drives the frame line.
    modport slave  (input req, dat, output gnt, dat_out, busy, frame_done);
endinterface
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin winner search starting one past
//                a registered last-winner pointer; pointer updates on take.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic            sys_clk,
    input  logic            rst,
    input  logic [NREQ-1:0] i_req,
    input  logic            i_take,
    output logic            o_any,
    output logic [IDW-1:0]  o_idx,
    output logic [IDW-1:0]  o_last
);
    logic [IDW-1:0]    r_last;
    logic [IDW:0]      w_shift;
    logic [2*NREQ-1:0] w_rot;
    int                w_off;

    // Rotate requests so bit 0 is the highest-priority requester, then take the lowest set bit.
    always_comb begin
        w_shift = {1'b0, r_last} + 1'b1;
        w_rot   = {i_req, i_req} >> w_shift;
        w_off   = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_off = k;
            end
        end
        o_any = |i_req;
        o_idx = IDW'((int'(r_last) + 1 + w_off) % NREQ);
    end

    // Remember the winner of every grant; reset points at NREQ-1 so requester 0 leads.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            r_last <= IDW'(NREQ - 1);
        end else if (i_take) begin
            r_last <= o_idx;
        end
    end

    assign o_last = r_last;

endmodule
`default_nettype wire

// File: rtl/serial_frame_arb.sv
`default_nettype none
// ============================================================================
//  Module      : serial_frame_arb
//  Description : Round-robin arbiter that serialises the winning requester's
//                payload as SYNC | ID | PAYLOAD | [PAR] | GAP on one line.
//                Optional parity bit: define SERIAL_FRAME_ARB_PARITY_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_frame_arb
    import serial_pkg::*;
#(
    parameter int             NREQ = 4,
    parameter int             LEN  = c_len_def,
    parameter logic [LEN-1:0] STD  = c_std_def,
    parameter int             DW   = c_dw_def,
    parameter int             GAP  = c_gap_def
) (
    input  logic                 sys_clk,
    input  logic                 rst,
    serial_frame_arb_if.slave    bus
);
    localparam int c_idw  = $clog2(NREQ);
    localparam int c_maxl = max_of(max_of(LEN, DW), max_of(GAP, c_idw));
    localparam int c_cw   = $clog2(c_maxl + 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [c_cw-1:0]   r_cnt;
    logic [c_cw-1:0]   w_cnt_nxt;
    logic [DW-1:0]     r_payload;
    logic [DW-1:0]     w_dat_sel;
    logic              w_take;
    logic              w_any;
    logic [c_idw-1:0]  w_win_idx;
    logic [c_idw-1:0]  w_last;
    logic              w_bit;
    logic [LEN-1:0]    w_sync_sh;
    logic [c_idw-1:0]  w_id_sh;
    logic [DW-1:0]     w_pay_sh;
    logic [NREQ-1:0]   r_gnt;
    logic              r_dat_out;
    logic              r_busy;
    logic              r_frame_done;

    // The arbiter's last-winner pointer doubles as the ID of the frame in flight.
    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (c_idw)
    ) u_arb (
        .sys_clk (sys_clk),
        .rst     (rst),
        .i_req   (bus.req),
        .i_take  (w_take),
        .o_any   (w_any),
        .o_idx   (w_win_idx),
        .o_last  (w_last)
    );

    // Payload slice of the current round-robin winner.
    always_comb begin
        w_dat_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_win_idx == c_idw'(i)) begin
                w_dat_sel = bus.dat[i*DW +: DW];
            end
        end
    end

    // Next state and bit counter; a new grant may come straight out of the last GAP cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + 1'b1;
        w_take      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_cnt_nxt = '0;
                if (w_any) begin
                    w_take      = 1'b1;
                    w_state_nxt = ST_SYNC;
                end
            end
            ST_SYNC: begin
                if (r_cnt == c_cw'(LEN - 1)) begin
                    w_state_nxt = ST_ID;
                    w_cnt_nxt   = '0;
                end
            end
            ST_ID: begin
                if (r_cnt == c_cw'(c_idw - 1)) begin
                    w_state_nxt = ST_PAYLOAD;
                    w_cnt_nxt   = '0;
                end
            end
            ST_PAYLOAD: begin
                if (r_cnt == c_cw'(DW - 1)) begin
`ifdef SERIAL_FRAME_ARB_PARITY_EN
                    w_state_nxt = ST_PAR;
`else
                    w_state_nxt = ST_GAP;
`endif
                    w_cnt_nxt   = '0;
                end
            end
`ifdef SERIAL_FRAME_ARB_PARITY_EN
            ST_PAR: begin
                w_state_nxt = ST_GAP;
                w_cnt_nxt   = '0;
            end
`endif
            ST_GAP: begin
                if (r_cnt == c_cw'(GAP - 1)) begin
                    w_cnt_nxt = '0;
                    if (w_any) begin
                        w_take      = 1'b1;
                        w_state_nxt = ST_SYNC;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // MSB-first bit selection: shift left by the bit count and read the top bit.
    assign w_sync_sh = STD << w_cnt_nxt;
    assign w_id_sh   = w_last << w_cnt_nxt;
    assign w_pay_sh  = r_payload << w_cnt_nxt;

    // Line value for the cycle being entered, so dat_out can be a plain register.
    always_comb begin
        w_bit = 1'b0;
        case (w_state_nxt)
            ST_SYNC:    w_bit = w_sync_sh[LEN-1];
            ST_ID:      w_bit = w_id_sh[c_idw-1];
            ST_PAYLOAD: w_bit = w_pay_sh[DW-1];
`ifdef SERIAL_FRAME_ARB_PARITY_EN
            ST_PAR:     w_bit = ^{w_last, r_payload};
`endif
            default:    w_bit = 1'b0;
        endcase
    end

    // FSM state, bit counter and payload capture at the grant edge.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_payload <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_take) begin
                r_payload <= w_dat_sel;
            end
        end
    end

    // Registered outputs describing the cycle the FSM is entering.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            r_gnt        <= '0;
            r_dat_out    <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_gnt        <= w_take ? (NREQ'(1) << w_win_idx) : '0;
            r_dat_out    <= w_bit;
            r_busy       <= (w_state_nxt != ST_IDLE);
            r_frame_done <= (w_state_nxt == ST_GAP) && (w_cnt_nxt == c_cw'(GAP - 1));
        end
    end

    assign bus.gnt        = r_gnt;
    assign bus.dat_out    = r_dat_out;
    assign bus.busy       = r_busy;
    assign bus.frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: doc/serial_frame_arb.md
SERIAL_FRAME_ARB -- requirements
Module: serial_frame_arb

Interface
REQ-001 Parameter NREQ, default 4, number of requesters; legal range 2..16.
REQ-002 Parameter LEN, default 5, sync pattern length in bits.
REQ-003 Parameter STD, default 5'b01110, sync pattern sent MSB first; it matches the pattern the downstream serial_detect searches for.
REQ-004 Parameter DW, default 8, payload width in bits.
REQ-005 Parameter GAP, default 2, idle-zero cycles after each frame; legal range 1..15.
REQ-006 sys_clk  input  1  single clock; all state changes on its rising edge.
REQ-007 rst  input  1  asynchronous, active-high reset.
REQ-008 req  input  NREQ  per-requester level request; req[i] is held while frame i is pending.
REQ-009 dat  input  NREQ*DW  payloads; requester i occupies bits [i*DW +: DW].
REQ-010 gnt  output  NREQ  one-hot, one-cycle grant pulse marking the cycle requester i's payload is captured.
REQ-011 dat_out  output  1  registered serial line toward serial_detect.
REQ-012 busy  output  1  high from the grant cycle through the last GAP cycle.
REQ-013 frame_done  output  1  one-cycle pulse on the last GAP cycle.

Function
REQ-014 FSM states: IDLE, SYNC, ID, PAYLOAD, PAR (macro only), GAP.
REQ-015 IDLE with any req bit high at a rising edge: register the round-robin winner, pulse gnt for that edge's cycle, capture its dat slice, and enter SYNC.
REQ-016 SYNC: LEN cycles, dat_out = STD[LEN-1] down to STD[0]; the first sync bit appears in the gnt cycle.
REQ-017 ID: IDW = clog2(NREQ) cycles, dat_out = winner index, MSB first.
REQ-018 PAYLOAD: DW cycles, dat_out = captured payload, MSB first.
REQ-019 GAP: GAP cycles with dat_out = 0, then IDLE; frame_done pulses on the final GAP cycle.
REQ-020 In IDLE, dat_out, busy and gnt are 0.
REQ-021 Round robin: the search starts at (last winner + 1) mod NREQ; after reset the last winner is NREQ-1, so requester 0 has priority first.
REQ-022 After capture, req or dat changes do not affect the frame in flight.
REQ-023 A req deasserted before a grant is never granted.
REQ-024 A requester holding req continuously is re-granted only after every other asserted requester has been served once.
REQ-025 The earliest possible next grant is the cycle after frame_done; back-to-back frames have no extra idle cycle.
REQ-026 One counter, sized for max(LEN, DW, GAP), indexes bits within each state and reloads on every state change.

Reset
REQ-027 rst high forces IDLE, gnt = 0, dat_out = 0, busy = 0, frame_done = 0, last winner = NREQ-1, and clears the counter and payload register, immediately and regardless of the clock.
REQ-028 Reset mid-frame abandons the frame; no grant is reissued for it.
REQ-029 The first grant can occur at the first rising edge after rst falls.

Configuration
REQ-030 Macro SERIAL_FRAME_ARB_PARITY_EN defined: PAR state inserted after PAYLOAD for one cycle, dat_out = even parity (XOR) over the ID and payload bits.
REQ-031 Macro undefined: no PAR state; PAYLOAD goes directly to GAP.

Structure
REQ-032 Package serial_pkg holds the FSM state encoding and the default LEN/STD/DW/GAP constants shared with serial_detect benches.
REQ-033 Winner selection is sub-module rr_arbiter: combinational round-robin with a registered last-winner pointer.

Verification
REQ-034 Defaults; req = 4'b0001 held at cycle 0, dat[7:0] = 8'hA5: gnt[0] pulses, dat_out = 0 1 1 1 0 | 0 0 | 1 0 1 0 0 1 0 1 | 0 0, frame_done on the 17th cycle, serial_detect find asserted.
REQ-035 req = 4'b1111 held continuously: grant order 0, 1, 2, 3, 0; consecutive gnt pulses exactly 17 cycles apart.
REQ-036 req = 4'b0100 then 4'b0110 added mid-frame: requester 2 completes, then requester 1 granted the cycle after frame_done.
REQ-037 rst pulsed during PAYLOAD: dat_out and busy drop to 0 asynchronously; after release, req = 4'b1000 is granted within 1 cycle.
REQ-038 SERIAL_FRAME_ARB_PARITY_EN defined, requester 3, dat = 8'h01: ID bits 1 1, then payload, then parity bit 1; frame_done on the 18th cycle.
